wb_port_arbiter: RTL

//  Shares the regfile's two write ports (instr1/instr2 writeback lanes) among NUM_REQ writeback sources (ALU0, ALU1, LSU, MUL).

---
 rtl/aqua_pkg.sv | 26 ++
 rtl/wb_port_arbiter_rr_pick2.sv | 61 ++++++
 rtl/wb_port_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/aqua_pkg.sv
// Shared types for the writeback path: the regfile write bundle and requester ids.
package aqua_pkg;

    localparam int unsigned WB_ADDR_W  = 5;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_NUM_REQ = 4;

    // Two regfile write lanes, presented together to the regfile each cycle
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd_addr_instr1;
        logic [WB_DATA_W-1:0] rd_data_instr1;
        logic                 wren_instr1;
        logic [WB_ADDR_W-1:0] rd_addr_instr2;
        logic [WB_DATA_W-1:0] rd_data_instr2;
        logic                 wren_instr2;
    } writeback_s;

    // Requester index assignment on the arbiter's request vector
    typedef enum logic [1:0] {
        WB_ALU0 = 2'd0,
        WB_ALU1 = 2'd1,
        WB_LSU  = 2'd2,
        WB_MUL  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Round-robin pick of up to two requesters with distinct, non-zero destination registers.
module rr_pick2 #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        valid,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
    input  logic [PTR_W-1:0]          rr_ptr,
    output logic [NUM_REQ-1:0]        grant1_c,
    output logic [NUM_REQ-1:0]        grant2_c,
    output logic                      hit1_c,
    output logic                      hit2_c,
    output logic [PTR_W-1:0]          idx1_c,
    output logic [PTR_W-1:0]          idx2_c
);

    localparam int unsigned PW1 = PTR_W + 1;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [PW1-1:0]    pos;
    logic [PTR_W-1:0]  k;
    logic [ADDR_W-1:0] rd1;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign addr_arr[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Scan from rr_ptr with an explicit wrap so k never exceeds NUM_REQ-1
    always_comb begin
        grant1_c = '0;
        grant2_c = '0;
        hit1_c   = 1'b0;
        hit2_c   = 1'b0;
        idx1_c   = '0;
        idx2_c   = '0;
        rd1      = '0;
        pos      = '0;
        k        = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pos = {1'b0, rr_ptr} + PW1'(i);
            if (pos >= PW1'(NUM_REQ)) begin
                pos = pos - PW1'(NUM_REQ);
            end
            k = pos[PTR_W-1:0];
            if (valid[k] && (addr_arr[k] != '0)) begin
                if (!hit1_c) begin
                    hit1_c      = 1'b1;
                    grant1_c[k] = 1'b1;
                    idx1_c      = k;
                    rd1         = addr_arr[k];
                end else if (!hit2_c && (addr_arr[k] != rd1)) begin
                    hit2_c      = 1'b1;
                    grant2_c[k] = 1'b1;
                    idx2_c      = k;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile's two write lanes among NUM_REQ writeback sources, round-robin.
module wb_port_arbiter
    import aqua_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_REQ,
    parameter int unsigned DATA_W  = WB_DATA_W,
    parameter int unsigned ADDR_W  = WB_ADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_rd_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_rd_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output writeback_s                o_wb_rf_pkg,
    output logic                      o_busy
);

    localparam int unsigned      PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   last_idx_c;
    logic [PTR_W-1:0]   rr_ptr_next_c;
    logic [NUM_REQ-1:0] grant1_c;
    logic [NUM_REQ-1:0] grant2_c;
    logic [NUM_REQ-1:0] x0_c;
    logic               hit1_c;
    logic               hit2_c;
    logic [PTR_W-1:0]   idx1_c;
    logic [PTR_W-1:0]   idx2_c;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    // Per-requester views of the flat buses; x0 writes are drained without a lane
    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign addr_arr[g] = i_req_rd_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = i_req_rd_data[g*DATA_W +: DATA_W];
        assign x0_c[g]     = i_req_valid[g] & (addr_arr[g] == '0);
    end

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) u_pick (
        .valid    (i_req_valid),
        .rd_addr  (i_req_rd_addr),
        .rr_ptr   (rr_ptr),
        .grant1_c (grant1_c),
        .grant2_c (grant2_c),
        .hit1_c   (hit1_c),
        .hit2_c   (hit2_c),
        .idx1_c   (idx1_c),
        .idx2_c   (idx2_c)
    );

    assign o_req_ready = i_rst ? '0 : (grant1_c | grant2_c | x0_c);
    assign o_busy      = |(i_req_valid & ~o_req_ready);

    // Pointer moves one past the last lane winner, wrapping at NUM_REQ
    always_comb begin
        last_idx_c    = hit2_c ? idx2_c : idx1_c;
        rr_ptr_next_c = (last_idx_c == LAST_IDX) ? '0 : last_idx_c + PTR_W'(1);
    end

    // Register lane winners toward the regfile; address/data hold on idle lanes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr      <= '0;
            o_wb_rf_pkg <= '0;
        end else begin
            o_wb_rf_pkg.wren_instr1 <= hit1_c;
            o_wb_rf_pkg.wren_instr2 <= hit2_c;
            if (hit1_c) begin
                o_wb_rf_pkg.rd_addr_instr1 <= WB_ADDR_W'(addr_arr[idx1_c]);
                o_wb_rf_pkg.rd_data_instr1 <= WB_DATA_W'(data_arr[idx1_c]);
                rr_ptr                     <= rr_ptr_next_c;
            end
            if (hit2_c) begin
                o_wb_rf_pkg.rd_addr_instr2 <= WB_ADDR_W'(addr_arr[idx2_c]);
                o_wb_rf_pkg.rd_data_instr2 <= WB_DATA_W'(data_arr[idx2_c]);
            end
        end
    end

endmodule
